// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter between a never-stalled ALU
// result path and in-order load responses. Load destination tags are queued
// at issue; returning data is paired with the oldest unpaired tag, written
// directly when nothing else competes, or parked in a small response buffer.
//
// Optional feature macro: WB_ARBITER_SCOREBOARD_EN
//   defined   -> busy_a/busy_b report pending-load hazards on decode sources
//   undefined -> busy_a/busy_b tied low, tag-match logic not built
module wb_arbiter #(
    parameter int LDQ_DEPTH  = 4,
    parameter int RSPQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_req_valid,
    input  logic [4:0]  ld_req_rd,
    output logic        ld_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        mem_rsp_ready,
    input  logic [4:0]  chk_adr_a,
    input  logic [4:0]  chk_adr_b,
    output logic        busy_a,
    output logic        busy_b,
    output logic        rf_we,
    output logic [4:0]  rf_adr_wrt,
    output logic [31:0] rf_data
);

    localparam int LAW = $clog2(LDQ_DEPTH);
    localparam int RAW = $clog2(RSPQ_DEPTH);
    localparam logic [LAW:0] LDQ_CNT_MAX  = LDQ_DEPTH[LAW:0];
    localparam logic [RAW:0] RSPQ_CNT_MAX = RSPQ_DEPTH[RAW:0];

    // Outstanding-load tag queue. Entry at head is the oldest load; the first
    // rsp_count_r entries from head already have data in the response buffer.
    logic [4:0]     tag_mem_r [LDQ_DEPTH];
    logic [LAW-1:0] tag_head_r;
    logic [LAW-1:0] tag_tail_r;
    logic [LAW:0]   tag_count_r;

    // Response buffer: data only, its head always pairs with the tag-queue head.
    logic [31:0]    rsp_mem_r [RSPQ_DEPTH];
    logic [RAW-1:0] rsp_head_r;
    logic [RAW-1:0] rsp_tail_r;
    logic [RAW:0]   rsp_count_r;

    logic        unpaired_s;
    logic        ld_push_s;
    logic        rsp_acc_s;
    logic        sel_alu_s;
    logic        sel_buf_s;
    logic        sel_dir_s;
    logic        ld_pop_s;
    logic        rsp_push_s;
    logic        rsp_pop_s;
    logic        wr_valid_s;
    logic [4:0]  wr_rd_s;
    logic [31:0] wr_data_s;

    assign ld_req_ready  = (tag_count_r < LDQ_CNT_MAX);
    assign mem_rsp_ready = (rsp_count_r < RSPQ_CNT_MAX);

    // A response is only meaningful if some issued load still awaits data;
    // otherwise it is a protocol error and is ignored.
    assign unpaired_s = (int'(tag_count_r) > int'(rsp_count_r));
    assign ld_push_s  = ld_req_valid && ld_req_ready;
    assign rsp_acc_s  = mem_rsp_valid && mem_rsp_ready && unpaired_s;

    // Pick this cycle's write source: ALU, then buffered data, then a fresh response.
    always_comb begin
        sel_alu_s = 1'b0;
        sel_buf_s = 1'b0;
        sel_dir_s = 1'b0;
        if (alu_valid) begin
            sel_alu_s = 1'b1;
        end else if (rsp_count_r != '0) begin
            sel_buf_s = 1'b1;
        end else if (rsp_acc_s) begin
            sel_dir_s = 1'b1;
        end else begin
            sel_alu_s = 1'b0;
        end
    end

    // Queue side effects of the selection: a load write retires the oldest tag,
    // an accepted response that lost arbitration is parked in the buffer.
    always_comb begin
        ld_pop_s   = sel_buf_s || sel_dir_s;
        rsp_pop_s  = sel_buf_s;
        rsp_push_s = rsp_acc_s && !sel_dir_s;
    end

    // Mux the selected source onto the pending write.
    always_comb begin
        wr_valid_s = 1'b0;
        wr_rd_s    = 5'd0;
        wr_data_s  = 32'd0;
        if (sel_alu_s) begin
            wr_valid_s = 1'b1;
            wr_rd_s    = alu_rd;
            wr_data_s  = alu_data;
        end else if (sel_buf_s) begin
            wr_valid_s = 1'b1;
            wr_rd_s    = tag_mem_r[tag_head_r];
            wr_data_s  = rsp_mem_r[rsp_head_r];
        end else if (sel_dir_s) begin
            wr_valid_s = 1'b1;
            wr_rd_s    = tag_mem_r[tag_head_r];
            wr_data_s  = mem_rsp_data;
        end else begin
            wr_valid_s = 1'b0;
        end
    end

    // Tag queue storage and pointers; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_head_r  <= '0;
            tag_tail_r  <= '0;
            tag_count_r <= '0;
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                tag_mem_r[i] <= 5'd0;
            end
        end else begin
            if (ld_push_s) begin
                tag_mem_r[tag_tail_r] <= ld_req_rd;
                tag_tail_r            <= tag_tail_r + LAW'(1'b1);
            end
            if (ld_pop_s) begin
                tag_head_r <= tag_head_r + LAW'(1'b1);
            end
            case ({ld_push_s, ld_pop_s})
                2'b10:   tag_count_r <= tag_count_r + (LAW+1)'(1'b1);
                2'b01:   tag_count_r <= tag_count_r - (LAW+1)'(1'b1);
                default: tag_count_r <= tag_count_r;
            endcase
        end
    end

    // Response buffer storage and pointers; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_head_r  <= '0;
            rsp_tail_r  <= '0;
            rsp_count_r <= '0;
            for (int i = 0; i < RSPQ_DEPTH; i++) begin
                rsp_mem_r[i] <= 32'd0;
            end
        end else begin
            if (rsp_push_s) begin
                rsp_mem_r[rsp_tail_r] <= mem_rsp_data;
                rsp_tail_r            <= rsp_tail_r + RAW'(1'b1);
            end
            if (rsp_pop_s) begin
                rsp_head_r <= rsp_head_r + RAW'(1'b1);
            end
            case ({rsp_push_s, rsp_pop_s})
                2'b10:   rsp_count_r <= rsp_count_r + (RAW+1)'(1'b1);
                2'b01:   rsp_count_r <= rsp_count_r - (RAW+1)'(1'b1);
                default: rsp_count_r <= rsp_count_r;
            endcase
        end
    end

    // Register the write port; r0 writes are swallowed and address/data hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_adr_wrt <= 5'd0;
            rf_data    <= 32'd0;
        end else if (wr_valid_s && (wr_rd_s != 5'd0)) begin
            rf_we      <= 1'b1;
            rf_adr_wrt <= wr_rd_s;
            rf_data    <= wr_data_s;
        end else begin
            rf_we      <= 1'b0;
            rf_adr_wrt <= rf_adr_wrt;
            rf_data    <= rf_data;
        end
    end

`ifdef WB_ARBITER_SCOREBOARD_EN
    logic           busy_a_s;
    logic           busy_b_s;
    logic [LAW-1:0] idx_v;

    // Compare decode sources against every live tag; a tag stays live until
    // the edge that registers its write, so hazard release is exact.
    always_comb begin
        busy_a_s = 1'b0;
        busy_b_s = 1'b0;
        idx_v    = '0;
        for (int k = 0; k < LDQ_DEPTH; k++) begin
            idx_v = tag_head_r + LAW'(k);
            if (k < int'(tag_count_r)) begin
                if ((chk_adr_a != 5'd0) && (tag_mem_r[idx_v] == chk_adr_a)) begin
                    busy_a_s = 1'b1;
                end else begin
                    busy_a_s = busy_a_s;
                end
                if ((chk_adr_b != 5'd0) && (tag_mem_r[idx_v] == chk_adr_b)) begin
                    busy_b_s = 1'b1;
                end else begin
                    busy_b_s = busy_b_s;
                end
            end else begin
                busy_a_s = busy_a_s;
            end
        end
    end

    assign busy_a = busy_a_s;
    assign busy_b = busy_b_s;
`else
    logic unused_chk_s;

    assign unused_chk_s = ^{chk_adr_a, chk_adr_b};
    assign busy_a       = 1'b0;
    assign busy_b       = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;

    localparam int LDQ  = 4;
    localparam int RSPQ = 2;
`ifdef WB_ARBITER_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        ld_req_valid = 1'b0;
    logic [4:0]  ld_req_rd = 5'd0;
    logic        ld_req_ready;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'd0;
    logic        mem_rsp_ready;
    logic [4:0]  chk_adr_a = 5'd0;
    logic [4:0]  chk_adr_b = 5'd0;
    logic        busy_a;
    logic        busy_b;
    logic        rf_we;
    logic [4:0]  rf_adr_wrt;
    logic [31:0] rf_data;

    wb_arbiter #(.LDQ_DEPTH(LDQ), .RSPQ_DEPTH(RSPQ)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_req_valid(ld_req_valid), .ld_req_rd(ld_req_rd), .ld_req_ready(ld_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
        .chk_adr_a(chk_adr_a), .chk_adr_b(chk_adr_b), .busy_a(busy_a), .busy_b(busy_b),
        .rf_we(rf_we), .rf_adr_wrt(rf_adr_wrt), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: list of issued loads in order, each possibly holding data.
    logic [4:0]  q_rd [$];
    bit          q_has [$];
    logic [31:0] q_dat [$];
    logic        exp_we = 1'b0;
    logic [4:0]  exp_adr = 5'd0;
    logic [31:0] exp_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_buffered();
        int n = 0;
        foreach (q_has[i]) if (q_has[i]) n++;
        return n;
    endfunction

    function automatic logic pending(input logic [4:0] a);
        if (!SB || a == 5'd0) return 1'b0;
        foreach (q_rd[i]) if (q_rd[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all();
        check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        check("rf_adr", {27'd0, rf_adr_wrt}, {27'd0, exp_adr});
        check("rf_data", rf_data, exp_data);
        check("ld_ready", {31'd0, ld_req_ready}, {31'd0, (q_rd.size() < LDQ)});
        check("rsp_ready", {31'd0, mem_rsp_ready}, {31'd0, (n_buffered() < RSPQ)});
        check("busy_a", {31'd0, busy_a}, {31'd0, pending(chk_adr_a)});
        check("busy_b", {31'd0, busy_b}, {31'd0, pending(chk_adr_b)});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alu_valid = 1'b0; ld_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        q_rd.delete(); q_has.delete(); q_dat.delete();
        exp_we = 1'b0; exp_adr = 5'd0; exp_data = 32'd0;
        check_all();
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, compare after the edge.
    task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lr,
                        input bit rv, input logic [31:0] rdat,
                        input logic [4:0] ca, input logic [4:0] cb);
        int nb;
        bit ldr, acc, wv, pop;
        logic [4:0] wrd;
        logic [31:0] wdat;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_req_valid = lv; ld_req_rd = lr;
        mem_rsp_valid = rv; mem_rsp_data = rdat;
        chk_adr_a = ca; chk_adr_b = cb;
        nb  = n_buffered();
        ldr = (q_rd.size() < LDQ);
        acc = rv && (nb < RSPQ) && (q_rd.size() > nb);
        wv = 1'b0; pop = 1'b0; wrd = 5'd0; wdat = 32'd0;
        if (av) begin
            wv = 1'b1; wrd = ar; wdat = ad;
        end else if (nb > 0) begin
            wv = 1'b1; wrd = q_rd[0]; wdat = q_dat[0]; pop = 1'b1;
        end else if (acc) begin
            wv = 1'b1; wrd = q_rd[0]; wdat = rdat; pop = 1'b1; acc = 1'b0;
        end
        if (acc) begin
            q_has[nb] = 1'b1; q_dat[nb] = rdat;
        end
        if (pop) begin
            void'(q_rd.pop_front()); void'(q_has.pop_front()); void'(q_dat.pop_front());
        end
        if (lv && ldr) begin
            q_rd.push_back(lr); q_has.push_back(1'b0); q_dat.push_back(32'd0);
        end
        exp_we = wv && (wrd != 5'd0);
        if (exp_we) begin
            exp_adr = wrd; exp_data = wdat;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle(input logic [4:0] ca);
        step(0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, ca, 5'd0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // ALU-only write, one cycle latency then idle
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 32'd0, 5'd0, 5'd0);
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_adr", {27'd0, rf_adr_wrt}, 32'd5);
        check("alu_data", rf_data, 32'hDEADBEEF);
        idle(5'd0);
        check("alu_we_off", {31'd0, rf_we}, 32'd0);
        check("hold_data", rf_data, 32'hDEADBEEF);

        // Load to r7, busy until write registered
        step(0, 5'd0, 32'd0, 1, 5'd7, 0, 32'd0, 5'd7, 5'd6);
        check("ld_busy", {31'd0, busy_a}, {31'd0, SB});
        idle(5'd7);
        step(0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h1234, 5'd7, 5'd0);
        check("ld_adr", {27'd0, rf_adr_wrt}, 32'd7);
        check("ld_data", rf_data, 32'h1234);
        check("ld_busy_clr", {31'd0, busy_a}, 32'd0);

        // Contention: ALU wins, buffered response follows
        step(0, 5'd0, 32'd0, 1, 5'd3, 0, 32'd0, 5'd3, 5'd4);
        step(1, 5'd4, 32'h44, 0, 5'd0, 1, 32'hA, 5'd3, 5'd4);
        check("cont_alu", {27'd0, rf_adr_wrt}, 32'd4);
        check("cont_busy", {31'd0, busy_a}, {31'd0, SB});
        idle(5'd3);
        check("cont_ld_adr", {27'd0, rf_adr_wrt}, 32'd3);
        check("cont_ld_data", rf_data, 32'hA);

        // Full queues under continuous ALU traffic, then drain
        for (int i = 1; i <= 4; i++) step(1, 5'd9, 32'(i), 1, 5'(i), 0, 32'd0, 5'd2, 5'd4);
        check("full_ldq", {31'd0, ld_req_ready}, 32'd0);
        step(1, 5'd9, 32'h90, 0, 5'd0, 1, 32'hB1, 5'd1, 5'd2);
        step(1, 5'd9, 32'h91, 0, 5'd0, 1, 32'hB2, 5'd1, 5'd2);
        check("full_rspq", {31'd0, mem_rsp_ready}, 32'd0);
        step(1, 5'd9, 32'h92, 0, 5'd0, 1, 32'hB3, 5'd1, 5'd2);
        idle(5'd1);
        check("drain1", rf_data, 32'hB1);
        idle(5'd2);
        check("drain2", rf_data, 32'hB2);
        check("drain_ld_ready", {31'd0, ld_req_ready}, 32'd1);
        check("drain_rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);

        // Load to r0: consumed silently
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 5'd0, 32'd0, 1, 5'd0, 0, 32'd0, 5'd0, 5'd0);
        check("r0_full", {31'd0, ld_req_ready}, 32'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h77, 5'd0, 5'd0);
        check("r0_we", {31'd0, rf_we}, 32'd0);
        check("r0_ready", {31'd0, ld_req_ready}, 32'd1);

        // Reset mid-operation discards everything
        do_reset();
        for (int i = 1; i <= 3; i++) step(0, 5'd0, 32'd0, 1, 5'(i + 10), 0, 32'd0, 5'd11, 5'd12);
        step(1, 5'd2, 32'h22, 0, 5'd0, 1, 32'hC0, 5'd11, 5'd12);
        do_reset();
        step(0, 5'd0, 32'd0, 0, 5'd0, 1, 32'hC1, 5'd11, 5'd12);
        check("post_rst_we", {31'd0, rf_we}, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 4, 5'($urandom_range(1, 7)), $urandom,
                     $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
                     $urandom_range(0, 9) < 5, $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
